// File: rtl/weight_loader.sv
// Streams 32-bit beats into four weight SRAM write ports in fixed bank order.
// Optional WLOAD_CHECKSUM_EN adds a running-sum check of the loaded stream.
module weight_loader #(
  parameter int N1 = 4096,
  parameter int N2 = 4096,
  parameter int N3 = 1024,
  parameter int N4 = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        cs1_wr,
  output logic        we1_wr,
  output logic        oe1_wr,
  output logic [11:0] addr1_wr,
  output logic [31:0] data1_wr,
  output logic        cs2_wr,
  output logic        we2_wr,
  output logic        oe2_wr,
  output logic [11:0] addr2_wr,
  output logic [31:0] data2_wr,
  output logic        cs3_wr,
  output logic        we3_wr,
  output logic        oe3_wr,
  output logic [9:0]  addr3_wr,
  output logic [31:0] data3_wr,
  output logic        cs4_wr,
  output logic        we4_wr,
  output logic        oe4_wr,
  output logic [7:0]  addr4_wr,
  output logic [15:0] data4_wr
`ifdef WLOAD_CHECKSUM_EN
  ,
  input  logic [31:0] chk_expected,
  output logic        chk_err
`endif
);

  typedef enum logic [2:0] {IDLE, L1, L2, L3, L4LO, L4HI} state_t;

  state_t      r_state, w_next;
  logic [11:0] r_idx;
  logic [11:0] w_limit;
  logic        w_at_end;
  logic        w_accept;
  logic        r_wr1, r_wr2, r_wr3, r_wr4, r_done;
  logic [11:0] r_addr1, r_addr2;
  logic [9:0]  r_addr3;
  logic [7:0]  r_addr4;
  logic [31:0] r_data1, r_data2, r_data3;
  logic [15:0] r_data4, r_hi;

  assign busy     = (r_state != IDLE);
  assign s_ready  = (r_state inside {L1, L2, L3, L4LO});
  assign w_accept = s_valid && s_ready;
  assign done     = r_done;

  assign cs1_wr = r_wr1;  assign we1_wr = r_wr1;  assign oe1_wr = 1'b0;
  assign cs2_wr = r_wr2;  assign we2_wr = r_wr2;  assign oe2_wr = 1'b0;
  assign cs3_wr = r_wr3;  assign we3_wr = r_wr3;  assign oe3_wr = 1'b0;
  assign cs4_wr = r_wr4;  assign we4_wr = r_wr4;  assign oe4_wr = 1'b0;
  assign addr1_wr = r_addr1;  assign data1_wr = r_data1;
  assign addr2_wr = r_addr2;  assign data2_wr = r_data2;
  assign addr3_wr = r_addr3;  assign data3_wr = r_data3;
  assign addr4_wr = r_addr4;  assign data4_wr = r_data4;

  // One shared word index; it wraps to 0 whenever the FSM moves to the next bank.
  always_comb begin
    w_limit = '0;
    case (r_state)
      L1:      w_limit = 12'(N1 - 1);
      L2:      w_limit = 12'(N2 - 1);
      L3:      w_limit = 12'(N3 - 1);
      L4HI:    w_limit = 12'(N4 - 1);
      default: w_limit = '0;
    endcase
    w_at_end = (r_idx == w_limit);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = L1;
      L1:      if (w_accept && w_at_end) w_next = L2;
      L2:      if (w_accept && w_at_end) w_next = L3;
      L3:      if (w_accept && w_at_end) w_next = L4LO;
      L4LO:    if (w_accept) w_next = L4HI;
      L4HI:    w_next = w_at_end ? IDLE : L4LO;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_wr1   <= 1'b0;  r_wr2 <= 1'b0;  r_wr3 <= 1'b0;  r_wr4 <= 1'b0;
      r_done  <= 1'b0;
      r_addr1 <= '0;  r_addr2 <= '0;  r_addr3 <= '0;  r_addr4 <= '0;
      r_data1 <= '0;  r_data2 <= '0;  r_data3 <= '0;  r_data4 <= '0;
      r_hi    <= '0;
    end else begin
      r_wr1  <= 1'b0;  r_wr2 <= 1'b0;  r_wr3 <= 1'b0;  r_wr4 <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) r_idx <= '0;
        L1: if (w_accept) begin
          r_wr1   <= 1'b1;
          r_addr1 <= r_idx;
          r_data1 <= s_data;
          r_idx   <= w_at_end ? '0 : r_idx + 12'd1;
        end
        L2: if (w_accept) begin
          r_wr2   <= 1'b1;
          r_addr2 <= r_idx;
          r_data2 <= s_data;
          r_idx   <= w_at_end ? '0 : r_idx + 12'd1;
        end
        L3: if (w_accept) begin
          r_wr3   <= 1'b1;
          r_addr3 <= r_idx[9:0];
          r_data3 <= s_data;
          r_idx   <= w_at_end ? '0 : r_idx + 12'd1;
        end
        L4LO: if (w_accept) begin
          r_wr4   <= 1'b1;
          r_addr4 <= r_idx[7:0];
          r_data4 <= s_data[15:0];
          r_hi    <= s_data[31:16];
          r_idx   <= r_idx + 12'd1;
        end
        L4HI: begin
          r_wr4   <= 1'b1;
          r_addr4 <= r_idx[7:0];
          r_data4 <= r_hi;
          r_done  <= w_at_end;
          r_idx   <= w_at_end ? '0 : r_idx + 12'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef WLOAD_CHECKSUM_EN
  logic [31:0] r_sum;
  logic        r_chk_err;

  assign chk_err = r_chk_err;

  // The final beat is accepted in L4LO, so r_sum is already complete in L4HI.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum     <= '0;
      r_chk_err <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_sum     <= '0;
      r_chk_err <= 1'b0;
    end else begin
      if (w_accept) r_sum <= r_sum + s_data;
      if (r_state == L4HI && w_at_end) r_chk_err <= (r_sum != chk_expected);
    end
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: the driver queues expected bank writes per
// accepted beat, a negedge monitor pops and compares every write strobe.
module tb_weight_loader;
  localparam int N1 = 4;
  localparam int N2 = 4;
  localparam int N3 = 2;
  localparam int N4 = 4;
  localparam int NB = N1 + N2 + N3 + N4 / 2;

  logic        clk = 1'b0;
  logic        rst_n, start, s_valid;
  logic [31:0] s_data;
  logic        busy, done, s_ready;
  logic        cs1_wr, we1_wr, oe1_wr, cs2_wr, we2_wr, oe2_wr;
  logic        cs3_wr, we3_wr, oe3_wr, cs4_wr, we4_wr, oe4_wr;
  logic [11:0] addr1_wr, addr2_wr;
  logic [9:0]  addr3_wr;
  logic [7:0]  addr4_wr;
  logic [31:0] data1_wr, data2_wr, data3_wr;
  logic [15:0] data4_wr;
`ifdef WLOAD_CHECKSUM_EN
  logic [31:0] chk_expected;
  logic        chk_err;
`endif

  weight_loader #(.N1(N1), .N2(N2), .N3(N3), .N4(N4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cs1_wr(cs1_wr), .we1_wr(we1_wr), .oe1_wr(oe1_wr), .addr1_wr(addr1_wr), .data1_wr(data1_wr),
    .cs2_wr(cs2_wr), .we2_wr(we2_wr), .oe2_wr(oe2_wr), .addr2_wr(addr2_wr), .data2_wr(data2_wr),
    .cs3_wr(cs3_wr), .we3_wr(we3_wr), .oe3_wr(oe3_wr), .addr3_wr(addr3_wr), .data3_wr(data3_wr),
    .cs4_wr(cs4_wr), .we4_wr(we4_wr), .oe4_wr(oe4_wr), .addr4_wr(addr4_wr), .data4_wr(data4_wr)
`ifdef WLOAD_CHECKSUM_EN
    , .chk_expected(chk_expected), .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    int          addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  wr_t         q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt;
  logic [31:0] beat_data [NB];
  bit          exp_chk_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference mapping of stream position k to bank writes.
  function automatic void push_beat(input int k, input logic [31:0] d);
    int j;
    if (k < N1)                q.push_back('{1, k, d, 1'b0});
    else if (k < N1 + N2)      q.push_back('{2, k - N1, d, 1'b0});
    else if (k < N1 + N2 + N3) q.push_back('{3, k - N1 - N2, d, 1'b0});
    else begin
      j = k - (N1 + N2 + N3);
      q.push_back('{4, 2 * j,     {16'h0, d[15:0]},  1'b0});
      q.push_back('{4, 2 * j + 1, {16'h0, d[31:16]}, (2 * j + 1) == N4 - 1});
    end
  endfunction

  // Monitor
  int          m_cnt, m_bank, m_addr;
  logic [31:0] m_data;
  wr_t         m_exp;
  always @(negedge clk) begin
    m_cnt = int'(cs1_wr) + int'(cs2_wr) + int'(cs3_wr) + int'(cs4_wr);
    if ({cs1_wr, cs2_wr, cs3_wr, cs4_wr} != {we1_wr, we2_wr, we3_wr, we4_wr})
      chk("cs_eq_we", {cs1_wr, cs2_wr, cs3_wr, cs4_wr}, {we1_wr, we2_wr, we3_wr, we4_wr});
    if ({oe1_wr, oe2_wr, oe3_wr, oe4_wr} != 4'b0)
      chk("oe_tied_low", {oe1_wr, oe2_wr, oe3_wr, oe4_wr}, 0);
    if (done) done_cnt++;
    if (m_cnt > 1) chk("one_bank_per_cycle", m_cnt, 1);
    else if (m_cnt == 1) begin
      if (cs1_wr)      begin m_bank = 1; m_addr = int'(addr1_wr); m_data = data1_wr; end
      else if (cs2_wr) begin m_bank = 2; m_addr = int'(addr2_wr); m_data = data2_wr; end
      else if (cs3_wr) begin m_bank = 3; m_addr = int'(addr3_wr); m_data = data3_wr; end
      else             begin m_bank = 4; m_addr = int'(addr4_wr); m_data = {16'h0, data4_wr}; end
      if (q.size() == 0) chk("unexpected_write_bank", m_bank, 0);
      else begin
        m_exp = q.pop_front();
        chk("wr_bank", m_bank, m_exp.bank);
        chk("wr_addr", m_addr, m_exp.addr);
        chk("wr_data", m_data, m_exp.data);
        chk("wr_done", done, {31'h0, m_exp.last});
        if (m_bank == 4 && m_addr[0] == 1'b0) chk("sready_in_l4hi", s_ready, 0);
`ifdef WLOAD_CHECKSUM_EN
        if (m_exp.last) chk("chk_err", chk_err, {31'h0, exp_chk_err});
`endif
      end
    end else if (done) chk("done_without_write", done, 0);
  end

  task automatic check_all_zero(input string nm);
    chk(nm, |{busy, done, s_ready, cs1_wr, we1_wr, oe1_wr, cs2_wr, we2_wr, oe2_wr,
              cs3_wr, we3_wr, oe3_wr, cs4_wr, we4_wr, oe4_wr,
              addr1_wr, addr2_wr, addr3_wr, addr4_wr,
              data1_wr, data2_wr, data3_wr, data4_wr}, 0);
  endtask

  // vmode: 0 back-to-back, 1 toggling valid, 2 random valid.
  task automatic run_seq(input int vmode, input int start_at, input int abort_at,
                         input logic [31:0] chk_exp);
    int          k = 0;
    int          cyc = 0;
    bit          tog = 1'b1;
    bit          v;
    logic [31:0] sum = '0;
    for (int i = 0; i < NB; i++) sum += beat_data[i];
    exp_chk_err = (sum != chk_exp);
    done_cnt = 0;
    @(negedge clk);
`ifdef WLOAD_CHECKSUM_EN
    chk_expected = chk_exp;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (k < NB && cyc < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      s_valid = v;
      s_data  = v ? beat_data[k] : $urandom;
      start   = (k == start_at);
      if (v && s_ready) begin
        push_beat(k, beat_data[k]);
        k++;
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (abort_at > 0 && k == abort_at) break;
    end
    s_valid = 1'b0;
    if (cyc >= 200) chk("beat_timeout", k, NB);
    if (abort_at > 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_all_zero("reset_mid_sequence");
      chk("queue_after_abort", q.size(), 0);
      q.delete();
    end else begin
      repeat (4) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      chk("done_once", done_cnt, 1);
      chk("idle_after_done", {busy, s_ready}, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
`ifdef WLOAD_CHECKSUM_EN
    chk_expected = '0;
`endif
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < NB; i++) beat_data[i] = 32'(i + 1);
    run_seq(0, -1, 0, 32'h4E);
    run_seq(1, -1, 0, 32'h4F);

    for (int i = 0; i < NB; i++) beat_data[i] = $urandom;
    run_seq(2, N1 + 1, 0, $urandom);

    for (int i = 0; i < NB; i++) beat_data[i] = 32'(i + 1);
    run_seq(0, -1, 6, 32'h4E);
    run_seq(0, -1, 0, 32'h4E);

    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < NB; i++) beat_data[i] = $urandom;
      beat_data[N1 + N2 + N3] = 32'hFFFF0001;
      run_seq(s % 3, -1, 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
